// File: rtl/cpu_trace_pkg.sv
// Shared state encoding, ASCII constants and BCD/hex digit helpers
// for the CPU trace line emitter.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    HEAD     = 4'd1,
    TIME     = 4'd2,
    AT       = 4'd3,
    PC       = 4'd4,
    SEP      = 4'd5,
    GRF_ADDR = 4'd6,
    ASSIGN   = 4'd7,
    DATA     = 4'd8,
    TAIL     = 4'd9
  } state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Index of the first digit to print; an all-zero value still prints digit 3.
  function automatic logic [1:0] bcd_first(input logic [15:0] v);
    if (v[15:12] != 4'd0) begin
      return 2'd0;
    end else if (v[11:8] != 4'd0) begin
      return 2'd1;
    end else if (v[7:4] != 4'd0) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] bcd_digit(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  function automatic logic [3:0] hex_digit(input logic [31:0] v, input logic [2:0] i);
    case (i)
      3'd0:    return v[31:28];
      3'd1:    return v[27:24];
      3'd2:    return v[23:20];
      3'd3:    return v[19:16];
      3'd4:    return v[15:12];
      3'd5:    return v[11:8];
      3'd6:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex/decimal digit.
module nibble_to_ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // 0-9 map to '0'-'9', a-f map to 'a'-'f'
  always_comb begin
    if (nib < 4'd10) begin
      ascii = 8'h30 + {4'h0, nib};
    end else begin
      ascii = 8'h57 + {4'h0, nib};
    end
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one latched register/memory write event into an ASCII trace
// line, one character per accepted handshake.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kind,
  input  logic [15:0] time_bcd,
  input  logic [31:0] pc,
  input  logic [15:0] grf_bcd,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        char_ready,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state, nxt_state, follow;
  logic [2:0]  idx, nxt_idx, follow_idx, field_last;
  logic        recover;
  logic        kind_q;
  logic [15:0] time_q, grf_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [1:0]  t_first, g_first;
  logic        xfer, fields_ok, accept, reject;
  logic [3:0]  nib;
  logic [7:0]  nib_char, nxt_char;

  assign xfer      = char_valid & char_ready;
  assign fields_ok = bcd_valid(time_bcd) & (kind | bcd_valid(grf_bcd));
  assign accept    = (state == IDLE) & start & fields_ok;
  assign reject    = (state == IDLE) & start & ~fields_ok;

  // Next state/index: step through the field, then jump to the next one
  always_comb begin
    nxt_state  = state;
    nxt_idx    = idx;
    field_last = 3'd0;
    follow     = IDLE;
    follow_idx = 3'd0;
    recover    = 1'b0;
    case (state)
      IDLE:     begin field_last = 3'd0; follow = HEAD; end
      HEAD:     begin field_last = 3'd0; follow = TIME; follow_idx = {1'b0, t_first}; end
      TIME:     begin field_last = 3'd3; follow = AT; end
      AT:       begin field_last = 3'd0; follow = PC; end
      PC:       begin field_last = 3'd7; follow = SEP; end
      SEP:      begin
        field_last = 3'd2;
        follow     = GRF_ADDR;
        follow_idx = kind_q ? 3'd0 : {1'b0, g_first};
      end
      GRF_ADDR: begin field_last = kind_q ? 3'd7 : 3'd3; follow = ASSIGN; end
      ASSIGN:   begin field_last = 3'd3; follow = DATA; end
      DATA:     begin field_last = 3'd7; follow = TAIL; end
      TAIL:     begin field_last = 3'd0; follow = IDLE; end
      default:  begin recover = 1'b1; end
    endcase
    if (state == IDLE) begin
      nxt_state = accept ? HEAD : IDLE;
      nxt_idx   = 3'd0;
    end else if (recover) begin
      nxt_state = IDLE;
      nxt_idx   = 3'd0;
    end else if (xfer) begin
      if (idx == field_last) begin
        nxt_state = follow;
        nxt_idx   = follow_idx;
      end else begin
        nxt_state = state;
        nxt_idx   = idx + 3'd1;
      end
    end else begin
      nxt_state = state;
      nxt_idx   = idx;
    end
  end

  // Digit source for the character about to be presented
  always_comb begin
    nib = 4'h0;
    case (nxt_state)
      TIME:     nib = bcd_digit(time_q, nxt_idx[1:0]);
      PC:       nib = hex_digit(pc_q, nxt_idx);
      GRF_ADDR: nib = kind_q ? hex_digit(addr_q, nxt_idx) : bcd_digit(grf_q, nxt_idx[1:0]);
      DATA:     nib = hex_digit(data_q, nxt_idx);
      default:  nib = 4'h0;
    endcase
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nib   (nib),
    .ascii (nib_char)
  );

  // Character for the next cycle; recomputed identically while stalled
  always_comb begin
    nxt_char = 8'h00;
    case (nxt_state)
      HEAD:                   nxt_char = CH_CARET;
      TIME, PC, GRF_ADDR, DATA: nxt_char = nib_char;
      AT:                     nxt_char = CH_AT;
      SEP: begin
        case (nxt_idx)
          3'd0:    nxt_char = CH_COLON;
          3'd1:    nxt_char = CH_SPACE;
          default: nxt_char = kind_q ? CH_STAR : CH_DOLLAR;
        endcase
      end
      ASSIGN: begin
        case (nxt_idx)
          3'd1:    nxt_char = CH_LT;
          3'd2:    nxt_char = CH_EQ;
          default: nxt_char = CH_SPACE;
        endcase
      end
      TAIL:                   nxt_char = CH_HASH;
      default:                nxt_char = 8'h00;
    endcase
  end

  // Sequencer state and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      char       <= 8'h00;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      char       <= nxt_char;
      char_valid <= (nxt_state != IDLE);
      busy       <= (nxt_state != IDLE);
      done       <= (state == TAIL) & xfer;
      err        <= reject;
    end
  end

  // Field snapshot taken only when a line is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q  <= 1'b0;
      time_q  <= 16'h0000;
      grf_q   <= 16'h0000;
      pc_q    <= 32'h0000_0000;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      t_first <= 2'd0;
      g_first <= 2'd0;
    end else if (accept) begin
      kind_q  <= kind;
      time_q  <= time_bcd;
      grf_q   <= grf_bcd;
      pc_q    <= pc;
      addr_q  <= addr;
      data_q  <= data;
      t_first <= bcd_first(time_bcd);
      g_first <= bcd_first(grf_bcd);
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Randomised self-checking bench for cpu_trace_emitter against a string-level
// model of the trace line format.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset, start, kind, char_ready;
  logic [15:0] time_bcd, grf_bcd;
  logic [31:0] pc, addr, data;
  logic [7:0]  char;
  logic        char_valid, busy, done, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_trace_emitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .kind       (kind),
    .time_bcd   (time_bcd),
    .pc         (pc),
    .grf_bcd    (grf_bcd),
    .addr       (addr),
    .data       (data),
    .char_ready (char_ready),
    .char       (char),
    .char_valid (char_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string bcd_str(input logic [15:0] v);
    int n;
    n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    return $sformatf("%0d", n);
  endfunction

  function automatic string model_line(input logic k, input logic [15:0] t, input logic [31:0] p,
                                       input logic [15:0] g, input logic [31:0] a, input logic [31:0] d);
    if (k)
      return {"^", bcd_str(t), "@", $sformatf("%08h", p), ": *", $sformatf("%08h", a),
              " <= ", $sformatf("%08h", d), "#"};
    else
      return {"^", bcd_str(t), "@", $sformatf("%08h", p), ": $", bcd_str(g),
              " <= ", $sformatf("%08h", d), "#"};
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v = 16'h0000;
    for (int i = 0; i < 4; i++)
      v = (v << 4) | 16'(($urandom_range(2) == 0) ? 0 : $urandom_range(9));
    return v;
  endfunction

  // Starts a line (from whatever cycle we are in) and receives it; returns in the done cycle.
  task automatic run_line(input string tag, input logic k, input logic [15:0] t, input logic [31:0] p,
                          input logic [15:0] g, input logic [31:0] a, input logic [31:0] d,
                          input int stall_pct, input bit poke, input string exp);
    string      rx = "";
    logic [7:0] held = 8'h00;
    bit         holding = 0;
    bit         finished = 0;
    bit         saw_hash = 0;
    int         cyc = 0;
    int         stray_done = 0;
    int         stray_err = 0;
    kind = k; time_bcd = t; pc = p; grf_bcd = g; addr = a; data = d;
    char_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_head"}, {char_valid, busy, done, char}, {1'b1, 1'b1, 1'b0, 8'h5e});
    while (cyc < 400 && !finished) begin
      if (holding) check({tag, "_hold"}, {char_valid, char}, {1'b1, held});
      if (done) stray_done++;
      if (err) stray_err++;
      if (poke && cyc < 5) begin
        start = 1'b1; kind = ~k; time_bcd = 16'h00A1; pc = $urandom; data = $urandom;
        addr = $urandom; grf_bcd = 16'h0777;
      end else begin
        start = 1'b0;
      end
      char_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      holding = 0;
      saw_hash = 0;
      if (char_valid && char_ready) begin
        rx = {rx, $sformatf("%c", char)};
        if (char == 8'h23) saw_hash = 1;
      end else if (char_valid) begin
        holding = 1;
        held = char;
      end
      tick();
      cyc++;
      if (saw_hash) finished = 1;
    end
    start = 1'b0;
    char_ready = 1'b1;
    check({tag, "_timeout"}, finished, 1'b1);
    check({tag, "_len"}, rx.len(), exp.len());
    check({tag, "_text"}, rx == exp, 1'b1);
    if (rx != exp) $display("  %s got \"%s\" expected \"%s\"", tag, rx, exp);
    if (stall_pct == 0) check({tag, "_cycles"}, cyc, exp.len());
    check({tag, "_no_early_done"}, stray_done, 0);
    check({tag, "_no_err"}, stray_err, 0);
    check({tag, "_done"}, {done, busy, char_valid}, {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    string       exp;
    logic        k;
    logic [15:0] t, g;
    logic [31:0] p, a, d;

    reset = 1'b1; start = 1'b1; kind = 1'b0; time_bcd = 16'h0123; pc = 32'h0000_3000;
    grf_bcd = 16'h0001; addr = 32'h0; data = 32'h1; char_ready = 1'b1;
    tick();
    tick();
    check("reset_outs", {char, char_valid, busy, done, err}, 12'h000);
    reset = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", {char_valid, busy, done, err}, 4'h0);

    run_line("reg_line", 1'b0, 16'h0123, 32'h0000_3000, 16'h0001, 32'h0, 32'h0000_0001, 0, 0,
             "^123@00003000: $1 <= 00000001#");
    // next start raised in the done cycle
    run_line("mem_line", 1'b1, 16'h0005, 32'h0000_3000, 16'h0000, 32'h0000_300C, 32'hDEAD_BEEF, 0, 0,
             "^5@00003000: *0000300c <= deadbeef#");
    tick();
    check("done_once", done, 1'b0);
    run_line("zero_line", 1'b0, 16'h0000, 32'h1234_5678, 16'h0000, 32'h0, 32'h0000_ABCD, 0, 0,
             "^0@12345678: $0 <= 0000abcd#");
    tick();
    run_line("stall_line", 1'b0, 16'h0123, 32'h0000_3000, 16'h0001, 32'h0, 32'h0000_0001, 40, 1,
             "^123@00003000: $1 <= 00000001#");
    tick();
    tick();
    check("no_late_start", {busy, char_valid}, 2'b00);

    kind = 1'b0; time_bcd = 16'h00A1; grf_bcd = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_time_pulse", {err, char_valid, busy}, 3'b100);
    tick();
    check("err_time_once", {err, char_valid, busy}, 3'b000);
    kind = 1'b0; time_bcd = 16'h0042; grf_bcd = 16'h1F00; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_grf_pulse", {err, char_valid, busy}, 3'b100);
    tick();
    check("err_grf_once", {err, char_valid, busy}, 3'b000);

    kind = 1'b1; time_bcd = 16'h0042; pc = $urandom; addr = $urandom; data = $urandom;
    char_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("rst_pre", {char_valid, busy}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid", {char_valid, busy, done}, 3'b000);
    tick();
    check("rst_no_done", {char_valid, busy, done}, 3'b000);
    p = $urandom; a = $urandom; d = $urandom;
    run_line("after_rst", 1'b1, 16'h9009, p, 16'hFFFF, a, d, 0, 0,
             model_line(1'b1, 16'h9009, p, 16'hFFFF, a, d));
    tick();

    for (int i = 0; i < 10; i++) begin
      k = 1'($urandom_range(1));
      t = rand_bcd();
      g = k ? 16'($urandom) : rand_bcd();
      p = $urandom; a = $urandom; d = $urandom;
      exp = model_line(k, t, p, g, a, d);
      run_line($sformatf("rnd%0d", i), k, t, p, g, a, d, (i % 2 == 0) ? 0 : 35, (i % 3 == 0), exp);
      if ($urandom_range(1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to emit one trace line; sampled only when busy=0.
REQ-004 SHALL have port: kind  input  1  line type: 0 = register write, 1 = memory write.
REQ-005 SHALL have port: time_bcd  input  16  four BCD digits, MS nibble first.
REQ-006 SHALL have port: pc  input  32  PC, emitted as 8 hex chars.
REQ-007 SHALL have port: grf_bcd  input  16  four BCD digits of the register number; used when kind=0.
REQ-008 SHALL have port: addr  input  32  memory address, emitted as 8 hex chars; used when kind=1.
REQ-009 SHALL have port: data  input  32  write data, emitted as 8 hex chars.
REQ-010 SHALL have port: char_ready  input  1  sink accepts char this cycle.
REQ-011 SHALL have port: char  output  8  ASCII character.
REQ-012 SHALL have port: char_valid  output  1  char holds a valid character.
REQ-013 SHALL have port: busy  output  1  a line is latched and in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse after the final '#' is transferred.
REQ-015 SHALL have port: err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-016 SHALL latch all field inputs on the edge where start=1 and busy=0; later input changes SHALL NOT affect the line.
REQ-017 SHALL emit, for kind=0: "^" T "@" PC ": $" G " <= " DATA "#".
REQ-018 SHALL emit, for kind=1: "^" T "@" PC ": *" ADDR " <= " DATA "#".
REQ-019 SHALL emit T and G in decimal with leading zeros stripped and at least one digit (BCD 0000 -> "0").
REQ-020 SHALL emit PC, ADDR and DATA as exactly 8 lowercase hex digits, MS nibble first, with zeros kept.
REQ-021 SHALL produce a total line length of 26+|T|+|G| characters for kind=0 and 34+|T| for kind=1.
REQ-022 SHALL drive all outputs from registers; '^' SHALL appear with char_valid=1 in the cycle after start is accepted.
REQ-023 SHALL transfer a character only on an edge where char_valid and char_ready are both 1; while char_valid=1 and char_ready=0, char SHALL hold stable.
REQ-024 SHALL sustain one character per cycle while char_ready stays high, with no bubbles between fields.
REQ-025 SHALL use states IDLE, HEAD, TIME, AT, PC, SEP, GRF_ADDR, ASSIGN, DATA, TAIL, plus a 3-bit digit/char index within each field.
REQ-026 SHALL, on the edge that transfers '#', clear busy and char_valid and pulse done for the next cycle.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL accept a start that is asserted in the done cycle, since busy=0 in that cycle.
REQ-029 SHALL reject a start at latch time if any time_bcd nibble is greater than 9, or if kind=0 and any grf_bcd nibble is greater than 9; on rejection it SHALL pulse err, emit nothing and stay in IDLE.

Reset
REQ-030 SHALL, when reset=1 at an edge, force state=IDLE, char=8'h00, char_valid=0, busy=0, done=0 and err=0.
REQ-031 SHALL, on reset mid-line, abort the line with no '#' and no done; reset SHALL take priority over a simultaneous start.

Structure
REQ-032 SHALL place the state encoding and ASCII constants ('^','@',':',' ','$','*','<','=','#') in the shared package cpu_trace_pkg.
REQ-033 SHALL instantiate one sub-module, nibble_to_ascii (4-bit in, 8-bit ASCII out; 0-9 -> '0'-'9', a-f -> 'a'-'f'), which is combinational and shared by all digit fields.

Verification
REQ-034 SHALL check: reset; start kind=0, time=16'h0123, pc=32'h00003000, grf=16'h0001, data=32'h00000001, char_ready=1 -> "^123@00003000: $1 <= 00000001#" (30 chars) on consecutive cycles, then done pulses once.
REQ-035 SHALL check: kind=1, time=16'h0005, pc=32'h00003000, addr=32'h0000300C, data=32'hDEADBEEF -> "^5@00003000: *0000300c <= deadbeef#" (35 chars).
REQ-036 SHALL check: time=16'h0000, grf=16'h0000 -> T="0" and G="0", line length 28.
REQ-037 SHALL check: random char_ready stalls -> char stable during every stall and the received string identical to the REQ-034 string; a start during busy is ignored.
REQ-038 SHALL check: time=16'h00A1 -> err pulses for 1 cycle, char_valid stays 0, busy stays 0.
REQ-039 SHALL check: reset asserted at the 10th character -> next cycle char_valid=0 and busy=0, no done pulse; a new start then emits a complete line beginning with '^'.
